// File: rtl/deflate_word_packer.sv
// Packs the deflate core's byte stream into 32-bit little-endian words
// and presents them on a valid/ready stream with keep/last and frame status.
module deflate_word_packer #(
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_vld,
    input  logic        in_done,
    input  logic [31:0] in_size,
    output logic [31:0] m_tdata,
    output logic [3:0]  m_tkeep,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [31:0] byte_count,
    output logic        size_mismatch,
    output logic        overflow,
    output logic        busy,
    output logic        frame_done
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        COLLECT,
        FLUSH,
        DRAIN
    } state_t;

    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } beat_t;

    state_t state, state_nx;

    logic [31:0] hold_data;
    logic [2:0]  lc;
    logic        new_frame;
    logic [31:0] size_q;

    beat_t              mem [DEPTH];
    logic [FIFO_AW:0]   wr_ptr, rd_ptr;
    logic               fifo_empty, fifo_full;
    logic               push, push_ok, pop;
    beat_t              push_beat, head;

    logic byte_acc, lost_in, drop;

    function automatic logic [3:0] lane_keep(input logic [2:0] n);
        logic [3:0] k;
        unique case (n)
            3'd0:    k = 4'b0000;
            3'd1:    k = 4'b0001;
            3'd2:    k = 4'b0011;
            3'd3:    k = 4'b0111;
            default: k = 4'b1111;
        endcase
        return k;
    endfunction

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign head       = mem[rd_ptr[FIFO_AW-1:0]];

    assign m_tvalid = !fifo_empty;
    assign m_tdata  = m_tvalid ? head.data : 32'd0;
    assign m_tkeep  = m_tvalid ? head.keep : 4'd0;
    assign m_tlast  = m_tvalid ? head.last : 1'b0;

    assign pop     = m_tvalid && m_tready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = push && (!fifo_full || pop);
    assign drop    = push && fifo_full && !pop;

    assign byte_acc   = (state == COLLECT) && in_vld;
    assign lost_in    = (state != COLLECT) && (in_vld || in_done);
    assign frame_done = (state == DRAIN) && pop && head.last;
    assign busy       = (state != COLLECT) || (lc != 3'd0) || !fifo_empty;

    always_comb begin
        state_nx  = state;
        push      = 1'b0;
        push_beat = '0;
        unique case (state)
            COLLECT: begin
                if (in_vld && lc == 3'd4) begin
                    push           = 1'b1;
                    push_beat.last = 1'b0;
                    push_beat.keep = 4'b1111;
                    push_beat.data = hold_data;
                end
                if (in_done) state_nx = FLUSH;
            end
            FLUSH: begin
                push           = 1'b1;
                push_beat.last = 1'b1;
                push_beat.keep = lane_keep(lc);
                push_beat.data = hold_data;
                state_nx       = DRAIN;
            end
            DRAIN: begin
                if (pop && head.last) state_nx = COLLECT;
            end
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= COLLECT;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_data <= '0;
            lc        <= '0;
        end else if (state == FLUSH) begin
            hold_data <= '0;
            lc        <= '0;
        end else if (byte_acc) begin
            if (lc == 3'd4) begin
                hold_data <= {24'd0, in_data};
                lc        <= 3'd1;
            end else begin
                for (int i = 0; i < 4; i++)
                    if (lc == 3'(i)) hold_data[8*i +: 8] <= in_data;
                lc <= lc + 3'd1;
            end
        end
    end

    // An empty frame reports zero bytes rather than the previous count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_count <= '0;
            new_frame  <= 1'b1;
        end else if (byte_acc) begin
            byte_count <= new_frame ? 32'd1 : byte_count + 32'd1;
            new_frame  <= 1'b0;
        end else begin
            if (state == COLLECT && in_done && new_frame)
                byte_count <= '0;
            if (frame_done)
                new_frame <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            size_q        <= '0;
            size_mismatch <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (state == COLLECT && in_done) size_q <= in_size;
            if (state == FLUSH) size_mismatch <= (byte_count != size_q);
            if (lost_in || drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= push_beat;
    end

endmodule

// File: tb/tb_deflate_word_packer.sv
// Directed and randomized checks of deflate_word_packer against a
// byte-list reference model of the expected output beats.
module tb_deflate_word_packer;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_vld = 1'b0;
    logic        in_done = 1'b0;
    logic [31:0] in_size = '0;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [31:0] byte_count;
    logic        size_mismatch;
    logic        overflow;
    logic        busy;
    logic        frame_done;

    int vectors = 0;
    int miscompares = 0;
    int fd_cnt = 0;
    int stall_err = 0;
    int ready_mode = 0;
    int cyc = 0;

    beat_t got_q[$];
    beat_t exp_q[$];

    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [31:0] pd = '0;
    logic [3:0]  pk = '0;

    deflate_word_packer #(.FIFO_AW(4)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_vld(in_vld),
        .in_done(in_done), .in_size(in_size),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_tlast(m_tlast), .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .byte_count(byte_count),
        .size_mismatch(size_mismatch),
        .overflow(overflow), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        case (ready_mode)
            0:       m_tready <= 1'b0;
            1:       m_tready <= 1'b1;
            2:       m_tready <= (cyc % 3 == 0);
            default: m_tready <= 1'($urandom % 2);
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            if (pv && !pr &&
                (!m_tvalid || m_tdata !== pd || m_tkeep !== pk || m_tlast !== pl))
                stall_err++;
            if (m_tvalid && m_tready)
                got_q.push_back({m_tdata, m_tkeep, m_tlast});
            if (frame_done) fd_cnt++;
            pv = m_tvalid; pr = m_tready;
            pd = m_tdata;  pk = m_tkeep; pl = m_tlast;
        end else begin
            pv = 1'b0; pr = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_frame(input logic [7:0] b[$],
                                        input bit mark_last);
        int n = b.size();
        beat_t t;
        if (n == 0) begin
            t.d = '0; t.k = '0; t.l = mark_last;
            exp_q.push_back(t);
            return;
        end
        for (int i = 0; i < n; i += 4) begin
            t.d = '0; t.k = '0;
            for (int j = 0; j < 4 && i + j < n; j++) begin
                t.d[8*j +: 8] = b[i+j];
                t.k[j] = 1'b1;
            end
            t.l = mark_last && (i + 4 >= n);
            exp_q.push_back(t);
        end
    endfunction

    task automatic send_frame(input logic [7:0] b[$], input bit done_on_last,
                              input logic [31:0] size);
        for (int i = 0; i < b.size(); i++) begin
            in_data = b[i];
            in_vld  = 1'b1;
            in_done = done_on_last && (i == b.size() - 1);
            in_size = size;
            tick();
        end
        in_vld = 1'b0;
        if (!done_on_last || b.size() == 0) begin
            in_done = 1'b1;
            in_size = size;
            tick();
        end
        in_done = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int target);
        for (int i = 0; i < 3000 && fd_cnt < target; i++) tick();
        check({tag, "_done_seen"}, fd_cnt, target);
    endtask

    task automatic compare_beats(input string tag);
        int n;
        check({tag, "_nbeats"}, got_q.size(), exp_q.size());
        n = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), got_q[i].d, exp_q[i].d);
            check($sformatf("%s_keep%0d", tag, i), 32'(got_q[i].k), 32'(exp_q[i].k));
            check($sformatf("%s_last%0d", tag, i), 32'(got_q[i].l), 32'(exp_q[i].l));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b[$];
        logic [7:0] big[$];
        logic [31:0] sz;
        int n;
        int fd0;

        // reset state
        tick(); tick();
        check("rst_tvalid", 32'(m_tvalid), 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tkeep", 32'(m_tkeep), 0);
        check("rst_tlast", 32'(m_tlast), 0);
        check("rst_bcount", byte_count, 0);
        check("rst_mism", 32'(size_mismatch), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fdone", 32'(frame_done), 0);
        rst = 1'b1;
        ready_mode = 1;
        tick(); tick();

        // 8 bytes, done after, size 8
        b = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        model_frame(b, 1);
        send_frame(b, 0, 32'd8);
        wait_fd("t1", 1);
        repeat (5) tick();
        compare_beats("t1");
        check("t1_one_pulse", fd_cnt, 1);
        check("t1_bcount", byte_count, 8);
        check("t1_mism", 32'(size_mismatch), 0);
        check("t1_busy", 32'(busy), 0);

        // 5 bytes, done on the 5th, size 6
        b = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        model_frame(b, 1);
        send_frame(b, 1, 32'd6);
        wait_fd("t2", 2);
        compare_beats("t2");
        check("t2_bcount", byte_count, 5);
        check("t2_mism", 32'(size_mismatch), 1);

        // empty frame
        b = {};
        model_frame(b, 1);
        send_frame(b, 0, 32'd0);
        wait_fd("t3", 3);
        compare_beats("t3");
        check("t3_bcount", byte_count, 0);
        check("t3_mism", 32'(size_mismatch), 0);

        // randomized frames with random backpressure
        ready_mode = 3;
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 40);
            b = {};
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            sz = ($urandom % 2 == 0) ? 32'(n) : 32'(n + $urandom_range(1, 3));
            model_frame(b, 1);
            send_frame(b, 1'($urandom % 2), sz);
            wait_fd($sformatf("rnd%0d", f), 4 + f);
            compare_beats($sformatf("rnd%0d", f));
            check($sformatf("rnd%0d_bcount", f), byte_count, 32'(n));
            check($sformatf("rnd%0d_mism", f), 32'(size_mismatch),
                  32'(sz != 32'(n)));
        end

        // 64 bytes with ready high one cycle in three
        ready_mode = 2;
        b = {};
        for (int i = 0; i < 64; i++) b.push_back(8'($urandom));
        model_frame(b, 1);
        send_frame(b, 0, 32'd64);
        wait_fd("t5", 10);
        compare_beats("t5");
        check("t5_stall_stable", stall_err, 0);
        check("t5_ovf", 32'(overflow), 0);
        check("t5_bcount", byte_count, 64);

        // 4096 bytes with no ready: FIFO fills, 17th word lost
        ready_mode = 0;
        tick();
        big = {};
        for (int i = 0; i < 4096; i++) big.push_back(8'($urandom));
        for (int i = 0; i < 4096; i++) begin
            in_data = big[i];
            in_vld  = 1'b1;
            tick();
            if (i == 67) check("t4_ovf_before", 32'(overflow), 0);
            if (i == 68) check("t4_ovf_after", 32'(overflow), 1);
        end
        in_vld  = 1'b0;
        in_done = 1'b1;
        in_size = 32'd4096;
        tick();
        in_done = 1'b0;
        check("t4_bcount", byte_count, 4096);
        fd0 = fd_cnt;
        ready_mode = 1;
        repeat (40) tick();
        b = {};
        for (int i = 0; i < 64; i++) b.push_back(big[i]);
        model_frame(b, 0);
        compare_beats("t4");
        check("t4_no_fdone", fd_cnt, fd0);
        check("t4_ovf_sticky", 32'(overflow), 1);
        check("t4_stall_stable", stall_err, 0);

        // clean reset, then reset mid-frame with 3 words buffered, lc=2
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("r0_ovf_clr", 32'(overflow), 0);
        ready_mode = 0;
        tick();
        b = {};
        for (int i = 0; i < 14; i++) b.push_back(8'($urandom));
        for (int i = 0; i < 14; i++) begin
            in_data = b[i];
            in_vld  = 1'b1;
            tick();
        end
        in_vld = 1'b0;
        tick();
        check("t6_pre_tvalid", 32'(m_tvalid), 1);
        check("t6_pre_busy", 32'(busy), 1);
        check("t6_pre_bcount", byte_count, 14);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_tvalid", 32'(m_tvalid), 0);
        check("t6_rst_tdata", m_tdata, 0);
        check("t6_rst_tkeep", 32'(m_tkeep), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_bcount", byte_count, 0);
        check("t6_rst_fdone", 32'(frame_done), 0);
        tick();
        rst = 1'b1;
        got_q.delete();
        exp_q.delete();
        fd_cnt = 0;
        ready_mode = 1;
        tick();
        b = {8'h11, 8'h22, 8'h33, 8'h44};
        model_frame(b, 1);
        send_frame(b, 0, 32'd4);
        wait_fd("t6", 1);
        repeat (5) tick();
        compare_beats("t6");
        check("t6_bcount", byte_count, 4);
        check("t6_mism", 32'(size_mismatch), 0);
        check("t6_ovf", 32'(overflow), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
